// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte handshake and serial status bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          i_TX_Valid;
  logic [7:0]    i_TX_Byte;
  logic          o_TX_Ready;
  logic          o_TX_Bit;
  logic          o_TX_Busy;
  logic [CW-1:0] o_FIFO_Count;

  modport master (
    output i_TX_Valid, i_TX_Byte,
    input  o_TX_Ready, o_TX_Bit, o_TX_Busy, o_FIFO_Count
  );

  modport slave (
    input  i_TX_Valid, i_TX_Byte,
    output o_TX_Ready, o_TX_Bit, o_TX_Busy, o_FIFO_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_fifo_if.slave tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_bit_q, tx_bit_d;
  logic          busy_q, busy_d;
  logic          ready, push, pop, bit_done;

  assign ready    = count_q < DEPTH_C;
  assign push     = tx.i_TX_Valid && ready;
  assign bit_done = baud_q == BAUD_LAST;
  // Popping in the last STOP cycle chains frames with no idle gap.
  assign pop      = (count_q != '0) && ((state_q == IDLE) || (state_q == STOP && bit_done));

  assign tx.o_TX_Ready   = ready;
  assign tx.o_TX_Bit     = tx_bit_q;
  assign tx.o_TX_Busy    = busy_q;
  assign tx.o_FIFO_Count = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_d    = bit_done ? '0 : baud_q + BW'(1);
    tx_bit_d  = tx_bit_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        baud_d   = '0;
        tx_bit_d = 1'b1;
        busy_d   = 1'b0;
      end
      START: if (bit_done) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
        tx_bit_d  = shift_q[0];
      end
      DATA: if (bit_done) begin
        if (bit_idx_q == 3'd7) begin
          state_d  = STOP;
          tx_bit_d = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          tx_bit_d  = shift_q[bit_idx_q + 3'd1];
        end
      end
      STOP: if (bit_done) begin
        state_d  = IDLE;
        tx_bit_d = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        baud_d   = '0;
        tx_bit_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
    if (pop) begin
      state_d  = START;
      shift_d  = mem_q[rd_ptr_q];
      baud_d   = '0;
      tx_bit_d = 1'b0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      tx_bit_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      tx_bit_q  <= tx_bit_d;
      busy_q    <= busy_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= tx.i_TX_Byte;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo at CLKS_PER_BIT 1 and 4
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) if1 ();
  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) if4 ();

  uart_tx_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (.i_clk(clk), .i_rst(rst), .tx(if1));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut4 (.i_clk(clk), .i_rst(rst), .tx(if4));

  logic       v_valid [2];
  logic [7:0] v_byte  [2];
  assign if1.i_TX_Valid = v_valid[0];
  assign if1.i_TX_Byte  = v_byte[0];
  assign if4.i_TX_Valid = v_valid[1];
  assign if4.i_TX_Byte  = v_byte[1];

  int passed = 0;
  int total  = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int cpb_of(input int m);
    return (m == 0) ? 1 : 4;
  endfunction

  function automatic logic dut_bit(input int m);
    return (m == 0) ? if1.o_TX_Bit : if4.o_TX_Bit;
  endfunction
  function automatic logic dut_busy(input int m);
    return (m == 0) ? if1.o_TX_Busy : if4.o_TX_Busy;
  endfunction
  function automatic logic dut_ready(input int m);
    return (m == 0) ? if1.o_TX_Ready : if4.o_TX_Ready;
  endfunction
  function automatic int dut_count(input int m);
    return (m == 0) ? int'(if1.o_FIFO_Count) : int'(if4.o_FIFO_Count);
  endfunction

  // Reference: a list of queued bytes plus the frame in flight, timed by cycles remaining.
  logic [7:0] m_buf [2][8];
  int         m_n    [2];
  bit         m_act  [2];
  int         m_left [2];
  logic [7:0] m_cur  [2];
  bit         mp_push, mp_pop;

  initial forever begin
    @(posedge clk or posedge rst);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_n[m] = 0; m_act[m] = 0; m_left[m] = 0;
      end else begin
        mp_push = v_valid[m] && (m_n[m] < DEPTH);
        mp_pop  = (!m_act[m] || m_left[m] == 1) && (m_n[m] > 0);
        if (m_act[m]) begin
          m_left[m]--;
          if (m_left[m] == 0) m_act[m] = 0;
        end
        if (mp_pop) begin
          m_cur[m] = m_buf[m][0];
          for (int i = 0; i < 7; i++) m_buf[m][i] = m_buf[m][i+1];
          m_n[m]--;
          m_act[m]  = 1;
          m_left[m] = 10 * cpb_of(m);
        end
        if (mp_push) begin
          m_buf[m][m_n[m]] = v_byte[m];
          m_n[m]++;
        end
      end
    end
  end

  function automatic logic exp_bit(input int m);
    int el, pos;
    if (!m_act[m]) return 1'b1;
    el  = 10 * cpb_of(m) - m_left[m];
    pos = el / cpb_of(m);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_cur[m][pos-1];
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("line%0d", m),  dut_bit(m),   exp_bit(m));
        check($sformatf("busy%0d", m),  dut_busy(m),  m_act[m]);
        check($sformatf("ready%0d", m), dut_ready(m), m_n[m] < DEPTH);
        check($sformatf("count%0d", m), dut_count(m), m_n[m]);
      end
    end
  end

  task automatic wait_idle(input int m);
    int n = 0;
    while ((m_act[m] || m_n[m] != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("wait_idle", dut_busy(m) | (n >= 2000), 1'b0);
  endtask

  task automatic grab_frame(input int m, output logic [7:0] b, output bit ok);
    int         cp;
    logic [9:0] first;
    logic       v;
    cp    = cpb_of(m);
    ok    = 1;
    first = '0;
    for (int s = 0; s < 10 * cp; s++) begin
      if (s > 0) @(negedge clk);
      v = dut_bit(m);
      if (s % cp == 0) first[s/cp] = v;
      else if (v !== first[s/cp]) ok = 0;
    end
    if (first[0] !== 1'b0 || first[9] !== 1'b1) ok = 0;
    b = first[8:1];
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs [5];
  logic [9:0] got;
  logic [49:0] line50;
  logic [7:0] rb;
  bit         rok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h81, 10'b1100000010};
    vecs[4] = '{8'h5A, 10'b1010110100};

    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin v_valid[m] = 1'b0; v_byte[m] = 8'h00; end
    repeat (3) @(negedge clk);
    check("rst_bit",   if1.o_TX_Bit,   1'b1);
    check("rst_ready", if1.o_TX_Ready, 1'b1);
    check("rst_busy",  if1.o_TX_Busy,  1'b0);
    check("rst_count", if1.o_FIFO_Count, 0);
    check("rst_bit4",  if4.o_TX_Bit,   1'b1);
    rst    = 1'b0;
    chk_en = 1;

    // Single frames at one clock per bit against hand-derived line patterns.
    for (int t = 0; t < 5; t++) begin
      wait_idle(0);
      v_valid[0] = 1'b1;
      v_byte[0]  = vecs[t].data;
      @(negedge clk);
      v_valid[0] = 1'b0;
      check("latency_idle", dut_bit(0), 1'b1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        got[i] = dut_bit(0);
      end
      check($sformatf("frame_%02h", vecs[t].data), got, vecs[t].frame);
      check($sformatf("rx_%02h", vecs[t].data), got[8:1], vecs[t].data);
    end

    // Overflow: six pushes into depth 4, five frames back-to-back.
    wait_idle(0);
    for (int c = 0; c < 52; c++) begin
      if (c < 6) begin
        v_valid[0] = 1'b1;
        v_byte[0]  = 8'(8'h11 + c);
        check($sformatf("ovf_ready_%0d", c), dut_ready(0), c < 5);
      end else begin
        v_valid[0] = 1'b0;
      end
      @(negedge clk);
      if (c >= 1 && c <= 50) line50[c-1] = dut_bit(0);
      if (c == 5)  check("ovf_count", dut_count(0), 4);
      if (c == 50) check("ovf_busy_end", dut_busy(0), 1'b1);
      if (c == 51) check("ovf_busy_off", dut_busy(0), 1'b0);
    end
    for (int f = 0; f < 5; f++) begin
      check($sformatf("ovf_start_%0d", f), line50[10*f],   1'b0);
      check($sformatf("ovf_stop_%0d", f),  line50[10*f+9], 1'b1);
      check($sformatf("ovf_rx_%0d", f),    line50[10*f+1 +: 8], 8'(8'h11 + f));
    end

    // Push on the same edge as the STOP->START pop with two bytes queued.
    wait_idle(0);
    for (int c = 0; c < 12; c++) begin
      v_valid[0] = (c < 3) || (c == 11);
      v_byte[0]  = 8'(8'hB0 + c);
      @(negedge clk);
      if (c == 10) check("pp_count_before", dut_count(0), 2);
      if (c == 11) check("pp_count_same",   dut_count(0), 2);
    end
    v_valid[0] = 1'b0;
    grab_frame(0, rb, rok);
    check("pp_frame1_ok", rok, 1'b1);
    check("pp_frame1", rb, 8'hB1);
    @(negedge clk);
    grab_frame(0, rb, rok);
    check("pp_frame2_ok", rok, 1'b1);
    check("pp_frame2", rb, 8'hB2);
    @(negedge clk);
    grab_frame(0, rb, rok);
    check("pp_frame3_ok", rok, 1'b1);
    check("pp_frame3", rb, 8'hBB);

    // Four clocks per bit.
    wait_idle(1);
    v_valid[1] = 1'b1;
    v_byte[1]  = 8'h3C;
    @(negedge clk);
    v_valid[1] = 1'b0;
    @(negedge clk);
    grab_frame(1, rb, rok);
    check("cpb4_hold_ok", rok, 1'b1);
    check("cpb4_byte", rb, 8'h3C);
    check("cpb4_busy_last", dut_busy(1), 1'b1);
    @(negedge clk);
    check("cpb4_busy_fall", dut_busy(1), 1'b0);

    // Reset in the middle of data bit 3 with bytes still queued.
    wait_idle(0);
    for (int c = 0; c < 3; c++) begin
      v_valid[0] = 1'b1;
      v_byte[0]  = (c == 0) ? 8'h52 : ((c == 1) ? 8'h66 : 8'h99);
      @(negedge clk);
    end
    v_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_bit3_before", dut_bit(0), 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_bit",   if1.o_TX_Bit,   1'b1);
    check("async_count", if1.o_FIFO_Count, 0);
    check("async_busy",  if1.o_TX_Busy,  1'b0);
    check("async_ready", if1.o_TX_Ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(0);
    v_valid[0] = 1'b1;
    v_byte[0]  = 8'hC3;
    @(negedge clk);
    v_valid[0] = 1'b0;
    @(negedge clk);
    grab_frame(0, rb, rok);
    check("post_rst_ok", rok, 1'b1);
    check("post_rst_byte", rb, 8'hC3);
    @(negedge clk);
    check("post_rst_busy",  dut_busy(0), 1'b0);
    check("post_rst_count", dut_count(0), 0);

    // Random traffic on both instances against the reference.
    for (int c = 0; c < 3000; c++) begin
      v_valid[0] = ($urandom_range(0, 2) == 0);
      v_byte[0]  = 8'($urandom);
      v_valid[1] = ($urandom_range(0, 11) == 0);
      v_byte[1]  = 8'($urandom);
      @(negedge clk);
    end
    v_valid[0] = 1'b0;
    v_valid[1] = 1'b0;
    repeat (400) @(negedge clk);
    check("drain_busy0", dut_busy(0), 1'b0);
    check("drain_busy1", dut_busy(1), 1'b0);

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
